// File: rtl/uart_rx_if.sv
// uart_rx_if: bundle of receiver outputs presented to the consumer.
//   rx_data       last received word, held until the next frame completes
//   rx_valid      one-clk pulse: frame complete, rx_data and flags valid
//   parity_error  odd-parity mismatch on the frame flagged by rx_valid
//   framing_error stop bit sampled low on the frame flagged by rx_valid
//   rx_busy       high from start-bit confirm until rx_valid
// Modports: master = receiver (drives), slave = consumer (observes).
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_error;
    logic                 framing_error;
    logic                 rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_error,
        output framing_error,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input parity_error,
        input framing_error,
        input rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 16x oversampled, LSB first.
// Detects and validates the start bit at mid-bit, samples each data bit at
// mid-bit, optionally checks odd parity, checks the stop bit, and presents
// the frame on rx_bus with a one-clk rx_valid pulse and error flags.
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   os_tick       16x-baud oversample strobe, one clk wide
//   rx_pin        serial line, asynchronous to clk, idle high
//   parity_enable frame carries an odd-parity bit; latched at start confirm
//   rx_bus        uart_rx_if.master: rx_data, rx_valid, parity_error,
//                 framing_error, rx_busy
// Build option: define UART_RX_PARITY_EN to build the parity state and check;
// otherwise parity_enable is ignored and parity_error is tied low.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         os_tick,
    input  logic         rx_pin,
    input  logic         parity_enable,
    uart_rx_if.master    rx_bus
);

    localparam int              IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [3:0]      MID_START = 4'd7;
    localparam logic [3:0]      MID_BIT   = 4'd15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    // Two-flop synchronizer; resets to the idle (high) line level.
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_pin;
            rxs     <= rx_meta;
        end
    end

    state_t                state, state_n;
    logic [3:0]            os_cnt, os_cnt_n;
    logic [IDX_W-1:0]      bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0]  shift_q, shift_n;
    logic [DATA_BITS-1:0]  data_q, data_n;
    logic                  ferr_q, ferr_n;
    logic                  valid_q, valid_n;
    logic                  busy_q, busy_n;
`ifdef UART_RX_PARITY_EN
    logic                  par_en_q, par_en_n;
    logic                  par_err_q, par_err_n;   // result of the parity sample, pending until stop
    logic                  perr_q, perr_n;
`else
    logic                  unused_parity_enable;
    assign unused_parity_enable = parity_enable;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            os_cnt    <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= 1'b0;
            par_err_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            os_cnt    <= os_cnt_n;
            bit_idx   <= bit_idx_n;
            shift_q   <= shift_n;
            data_q    <= data_n;
            ferr_q    <= ferr_n;
            valid_q   <= valid_n;
            busy_q    <= busy_n;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= par_en_n;
            par_err_q <= par_err_n;
            perr_q    <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        os_cnt_n  = os_cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift_q;
        data_n    = data_q;
        ferr_n    = ferr_q;
        valid_n   = 1'b0;
        busy_n    = busy_q;
`ifdef UART_RX_PARITY_EN
        par_en_n  = par_en_q;
        par_err_n = par_err_q;
        perr_n    = perr_q;
`endif
        case (state)
            IDLE: begin
                os_cnt_n = '0;
                if (os_tick && !rxs) begin
                    state_n = START;
                end
            end

            START: begin
                if (os_tick) begin
                    if (os_cnt == MID_START) begin
                        if (!rxs) begin
                            state_n   = DATA;
                            os_cnt_n  = '0;
                            bit_idx_n = '0;
                            busy_n    = 1'b1;
`ifdef UART_RX_PARITY_EN
                            par_en_n  = parity_enable;
                            par_err_n = 1'b0;
`endif
                        end else begin
                            // Start bit did not hold to mid-bit: glitch.
                            state_n = IDLE;
                        end
                    end else begin
                        os_cnt_n = os_cnt + 4'd1;
                    end
                end
            end

            DATA: begin
                if (os_tick) begin
                    // 4-bit counter wraps 15 -> 0, so samples fall 16 ticks apart.
                    os_cnt_n = os_cnt + 4'd1;
                    if (os_cnt == MID_BIT) begin
                        shift_n = {rxs, shift_q[DATA_BITS-1:1]};
                        if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_n = par_en_q ? PARITY : STOP;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bit_idx_n = bit_idx + 1'b1;
                        end
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (os_tick) begin
                    os_cnt_n = os_cnt + 4'd1;
                    if (os_cnt == MID_BIT) begin
                        // Odd parity: data ones plus parity bit must be odd.
                        par_err_n = ~(^shift_q ^ rxs);
                        state_n   = STOP;
                    end
                end
            end
`endif

            STOP: begin
                if (os_tick) begin
                    os_cnt_n = os_cnt + 4'd1;
                    if (os_cnt == MID_BIT) begin
                        data_n  = shift_q;
                        ferr_n  = !rxs;
                        valid_n = 1'b1;
                        busy_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_n  = par_err_q;
`endif
                        // A low stop bit may be a break; wait for the line to
                        // return high before hunting for another start bit.
                        state_n = rxs ? IDLE : WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                os_cnt_n = '0;
                if (rxs) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n  = IDLE;
                os_cnt_n = '0;
                busy_n   = 1'b0;
            end
        endcase
    end

    assign rx_bus.rx_data       = data_q;
    assign rx_bus.rx_valid      = valid_q;
    assign rx_bus.framing_error = ferr_q;
    assign rx_bus.rx_busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.parity_error  = perr_q;
`else
    assign rx_bus.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// Serial frames are driven one bit per 16 os_ticks (one os_tick every 4 clk);
// expected words are queued as each frame is launched and compared when the
// receiver pulses rx_valid.
module tb_uart_rx;

    localparam int DB         = 8;
    localparam int TICK_DIV   = 4;
    localparam int BIT_TICKS  = 16;
    localparam int BUSY_CLKS  = 9 * BIT_TICKS * TICK_DIV;  // mid start to mid stop

    logic clk           = 1'b0;
    logic reset_n       = 1'b0;
    logic os_tick       = 1'b0;
    logic rx_pin        = 1'b1;
    logic parity_enable = 1'b0;

    uart_rx_if #(.DATA_BITS(DB)) rx_bus ();

    uart_rx #(.DATA_BITS(DB)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .os_tick       (os_tick),
        .rx_pin        (rx_pin),
        .parity_enable (parity_enable),
        .rx_bus        (rx_bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   busy_clks = 0;

    // One-clk os_tick every TICK_DIV clocks, changed on the falling edge.
    initial begin : tick_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            os_tick = (ph == 0);
            ph = (ph + 1) % TICK_DIV;
        end
    end

    // Scoreboard monitor: sampled on the falling edge.
    initial begin : monitor
        logic valid_prev;
        exp_t e;
        valid_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_bus.rx_busy) busy_clks++;
            if (rx_bus.rx_valid) begin
                n_tests++;
                if (valid_prev !== 1'b0) begin
                    n_fail++;
                    $display("FAIL valid_width: rx_valid high on consecutive clocks, required single-clk pulse");
                end
                n_tests++;
                if (rx_bus.rx_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_at_valid: rx_busy=%b, required 0", rx_bus.rx_busy);
                end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: data=%h perr=%b ferr=%b, no frame expected",
                             rx_bus.rx_data, rx_bus.parity_error, rx_bus.framing_error);
                end else begin
                    e = exp_q.pop_front();
                    if ({rx_bus.rx_data, rx_bus.parity_error, rx_bus.framing_error} !== e) begin
                        n_fail++;
                        $display("FAIL frame: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                                 rx_bus.rx_data, rx_bus.parity_error, rx_bus.framing_error,
                                 e.data, e.perr, e.ferr);
                    end
                end
            end
            valid_prev = rx_bus.rx_valid;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge clk iff os_tick);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit with_par, input bit pbit,
                              input int stop_low);
        rx_pin = 1'b0;
        wait_ticks(BIT_TICKS);
        for (int i = 0; i < DB; i++) begin
            rx_pin = d[i];
            wait_ticks(BIT_TICKS);
        end
        if (with_par) begin
            rx_pin = pbit;
            wait_ticks(BIT_TICKS);
        end
        if (stop_low > 0) begin
            rx_pin = 1'b0;
            wait_ticks(stop_low);
        end
        rx_pin = 1'b1;
        wait_ticks(BIT_TICKS);
    endtask

    // Bounded wait for the scoreboard to empty; callers compare afterwards.
    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx_pin  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (rx_bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, required 00", rx_bus.rx_data); end
        n_tests++; if (rx_bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", rx_bus.rx_valid); end
        n_tests++; if (rx_bus.parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b, required 0", rx_bus.parity_error); end
        n_tests++; if (rx_bus.framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b, required 0", rx_bus.framing_error); end
        n_tests++; if (rx_bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", rx_bus.rx_busy); end
        @(negedge clk);
        reset_n = 1'b1;
        wait_ticks(20);
        n_tests++; if (rx_bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, required 0", rx_bus.rx_busy); end
    endtask

    task automatic test_basic();
        busy_clks = 0;
        exp_q.push_back('{data: 8'hA5, perr: 1'b0, ferr: 1'b0});
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        wait_drain();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_drain: %0d frames outstanding, required 0", exp_q.size()); exp_q.delete(); end
        n_tests++; if (busy_clks != BUSY_CLKS) begin n_fail++; $display("FAIL basic_busy_len: got %0d clk, required %0d", busy_clks, BUSY_CLKS); end
    endtask

    task automatic test_parity();
        parity_enable = 1'b1;
`ifdef UART_RX_PARITY_EN
        exp_q.push_back('{data: 8'h03, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h03, 1'b1, 1'b1, 0);
        exp_q.push_back('{data: 8'h03, perr: 1'b1, ferr: 1'b0});
        send_frame(8'h03, 1'b1, 1'b0, 0);
        wait_drain();
        n_tests++; if (rx_bus.parity_error !== 1'b1) begin n_fail++; $display("FAIL parity_hold: got %b, required 1", rx_bus.parity_error); end
`else
        exp_q.push_back('{data: 8'h03, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h03, 1'b0, 1'b0, 0);
        wait_drain();
        n_tests++; if (rx_bus.parity_error !== 1'b0) begin n_fail++; $display("FAIL parity_tied: got %b, required 0", rx_bus.parity_error); end
`endif
        parity_enable = 1'b0;
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL parity_drain: %0d frames outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_framing();
        busy_clks = 0;
        exp_q.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b1});
        send_frame(8'h55, 1'b0, 1'b0, 3 * BIT_TICKS);
        wait_drain();
        // Any false start inside the break would add busy time.
        n_tests++; if (busy_clks != BUSY_CLKS) begin n_fail++; $display("FAIL break_busy: got %0d clk, required %0d", busy_clks, BUSY_CLKS); end
        n_tests++; if (rx_bus.framing_error !== 1'b1) begin n_fail++; $display("FAIL ferr_hold: got %b, required 1", rx_bus.framing_error); end
        exp_q.push_back('{data: 8'h0F, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h0F, 1'b0, 1'b0, 0);
        wait_drain();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL framing_drain: %0d frames outstanding, required 0", exp_q.size()); exp_q.delete(); end
        n_tests++; if (rx_bus.framing_error !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b, required 0", rx_bus.framing_error); end
    endtask

    task automatic test_glitch();
        busy_clks = 0;
        rx_pin = 1'b0;
        wait_ticks(4);
        rx_pin = 1'b1;
        wait_ticks(2 * BIT_TICKS);
        n_tests++; if (busy_clks != 0) begin n_fail++; $display("FAIL glitch_busy: got %0d busy clk, required 0", busy_clks); end
        n_tests++; if (rx_bus.rx_data !== 8'h0F) begin n_fail++; $display("FAIL glitch_data: got %h, required 0F", rx_bus.rx_data); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h96;
        rx_pin = 1'b0;
        wait_ticks(BIT_TICKS);
        for (int i = 0; i < 4; i++) begin
            rx_pin = d[i];
            wait_ticks(BIT_TICKS);
        end
        rx_pin = d[4];
        wait_ticks(BIT_TICKS / 2);
        n_tests++; if (rx_bus.rx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b, required 1", rx_bus.rx_busy); end
        n_tests++; if (rx_bus.rx_data !== 8'h0F) begin n_fail++; $display("FAIL mid_held_data: got %h, required 0F", rx_bus.rx_data); end
        reset_n = 1'b0;
        #1;
        n_tests++; if (rx_bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", rx_bus.rx_busy); end
        n_tests++; if (rx_bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL abort_data: got %h, required 00", rx_bus.rx_data); end
        n_tests++; if ({rx_bus.rx_valid, rx_bus.parity_error, rx_bus.framing_error} !== 3'b000) begin
            n_fail++; $display("FAIL abort_flags: got valid/perr/ferr=%b%b%b, required 000",
                               rx_bus.rx_valid, rx_bus.parity_error, rx_bus.framing_error);
        end
        rx_pin = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_ticks(2 * BIT_TICKS);
        exp_q.push_back('{data: 8'hC3, perr: 1'b0, ferr: 1'b0});
        send_frame(8'hC3, 1'b0, 1'b0, 0);
        wait_drain();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL after_reset_drain: %0d frames outstanding, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b0});
        exp_q.push_back('{data: 8'hFF, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h00, 1'b0, 1'b0, 0);
        send_frame(8'hFF, 1'b0, 1'b0, 0);
        wait_drain();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d frames outstanding, required 0", exp_q.size()); exp_q.delete(); end
        n_tests++; if (rx_bus.rx_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_hold: got %h, required FF", rx_bus.rx_data); end
    endtask

    initial begin : main
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        wait_ticks(BIT_TICKS);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
